// File: rtl/mips_alu_exec.sv
// Registered, handshaked MIPS ALU execute unit with a WIDTH-cycle shift-add multiplier.
// Optional signed-overflow flag is built when ALU_OVERFLOW_EN is defined.
module mips_alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   result_q;
  logic               illegal_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]   count_q;

  logic               accept;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   alu_res_d;
  logic               alu_ill_d;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign illegal_op = illegal_q;

  assign sum  = operand_a + operand_b;
  assign diff = operand_a - operand_b;

  always_comb begin
    alu_res_d = '0;
    alu_ill_d = 1'b0;
    case (alu_control)
      OP_AND: alu_res_d = operand_a & operand_b;
      OP_OR:  alu_res_d = operand_a | operand_b;
      OP_ADD: alu_res_d = sum;
      OP_XOR: alu_res_d = operand_a ^ operand_b;
      OP_SUB: alu_res_d = diff;
      OP_SLT: alu_res_d[0] = ($signed(operand_a) < $signed(operand_b));
      OP_NOR: alu_res_d = ~(operand_a | operand_b);
      OP_MUL: alu_res_d = '0;
      default: alu_ill_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
    end else if (accept) begin
      if (alu_control == OP_MUL) begin
        state_q  <= S_MUL;
        mcand_q  <= operand_a;
        mplier_q <= operand_b;
        acc_q    <= '0;
        count_q  <= '0;
      end else begin
        state_q   <= S_DONE;
        result_q  <= alu_res_d;
        illegal_q <= alu_ill_d;
      end
    end else begin
      case (state_q)
        S_MUL: begin
          // One extra cycle after the last step moves the product into result.
          if (count_q == CNT_W'(WIDTH)) begin
            state_q   <= S_DONE;
            result_q  <= acc_q;
            illegal_q <= 1'b0;
          end else begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 1'b1;
          end
        end
        S_DONE: if (out_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic ovf_q;
  logic alu_ovf_d;

  always_comb begin
    alu_ovf_d = 1'b0;
    if (alu_control == OP_ADD)
      alu_ovf_d = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) && (sum[WIDTH-1] != operand_a[WIDTH-1]);
    else if (alu_control == OP_SUB)
      alu_ovf_d = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) && (diff[WIDTH-1] != operand_a[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ovf_q <= 1'b0;
    else if (accept) ovf_q <= alu_ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mips_alu_exec.sv
// Directed bench for mips_alu_exec: hand-computed vectors checked with immediate assertions.
module tb_mips_alu_exec;

  localparam int W = 32;
`ifdef ALU_OVERFLOW_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_control;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal_op;
  logic         overflow;

  int vectors = 0;
  int errs    = 0;

  mips_alu_exec #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal_op  (illegal_op),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single edge; caller ensures in_ready is high.
  task automatic do_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    alu_control = c;
    operand_a   = a;
    operand_b   = b;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    while (!out_valid && n < limit) begin
      tick();
      n++;
    end
    chk("wait_out_valid", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = 4'b0000; operand_a = '0; operand_b = '0;
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD then SUB back-to-back
    out_ready = 1'b1;
    alu_control = 4'b0010; operand_a = 32'h5; operand_b = 32'h3; in_valid = 1'b1;
    tick();
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_result", result, 32'h8);
    chk("add_zero", {31'd0, zero}, 32'd0);
    chk("add_in_ready", {31'd0, in_ready}, 32'd1);
    chk("add_ovf", {31'd0, overflow}, 32'd0);
    alu_control = 4'b0110; operand_a = 32'h5; operand_b = 32'h5;
    tick();
    in_valid = 1'b0;
    chk("sub_valid", {31'd0, out_valid}, 32'd1);
    chk("sub_result", result, 32'h0);
    chk("sub_zero", {31'd0, zero}, 32'd1);
    chk("sub_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

    do_op(4'b0111, 32'hFFFF_FFFF, 32'h1);
    chk("slt_neg", result, 32'h1);
    do_op(4'b0111, 32'h1, 32'hFFFF_FFFF);
    chk("slt_pos", result, 32'h0);
    chk("slt_zero", {31'd0, zero}, 32'd1);
    do_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("and", result, 32'hF000_F000);
    do_op(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("or", result, 32'hFFF0_FFF0);
    do_op(4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("xor", result, 32'h0FF0_0FF0);
    do_op(4'b1100, 32'h0F0F_0000, 32'h00F0_0000);
    chk("nor", result, 32'hF000_FFFF);
    do_op(4'b0010, 32'hFFFF_FFFF, 32'h2);
    chk("add_wrap", result, 32'h1);
    do_op(4'b0110, 32'h3, 32'h5);
    chk("sub_wrap", result, 32'hFFFF_FFFE);

    do_op(4'b0101, 32'h1234, 32'h5678);
    chk("ill_valid", {31'd0, out_valid}, 32'd1);
    chk("ill_result", result, 32'h0);
    chk("ill_flag", {31'd0, illegal_op}, 32'd1);
    chk("ill_zero", {31'd0, zero}, 32'd1);
    do_op(4'b0010, 32'h1, 32'h1);
    chk("ill_cleared", {31'd0, illegal_op}, 32'd0);

    do_op(4'b0010, 32'h7FFF_FFFF, 32'h1);
    chk("ovf_add_result", result, 32'h8000_0000);
    chk("ovf_add_flag", {31'd0, overflow}, {31'd0, OVF_ON});
    do_op(4'b0110, 32'h8000_0000, 32'h1);
    chk("ovf_sub_result", result, 32'h7FFF_FFFF);
    chk("ovf_sub_flag", {31'd0, overflow}, {31'd0, OVF_ON});
    do_op(4'b0000, 32'h7FFF_FFFF, 32'h1);
    chk("ovf_and_flag", {31'd0, overflow}, 32'd0);
    tick();

    // MUL 12*10 with a held result
    out_ready = 1'b0;
    do_op(4'b1000, 32'hC, 32'hA);
    for (int i = 0; i < 32; i++) begin
      chk("mul_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mul_out_valid", {31'd0, out_valid}, 32'd0);
      if (i == 5) begin
        alu_control = 4'b0010; operand_a = 32'h1; operand_b = 32'h1; in_valid = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("mul_edge32_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("mul_edge33_valid", {31'd0, out_valid}, 32'd1);
    chk("mul_result", result, 32'h78);
    for (int i = 0; i < 3; i++) begin
      alu_control = 4'b0011; operand_a = 32'hFFFF; operand_b = 32'h1; in_valid = 1'b1;
      tick();
      chk("mul_hold_result", result, 32'h78);
      chk("mul_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("mul_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("mul_release", {31'd0, out_valid}, 32'd0);

    do_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(40);
    chk("mul_max", result, 32'h1);
    tick();

    // Reset in the middle of a MUL
    do_op(4'b1000, 32'h7, 32'h9);
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_async_valid", {31'd0, out_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_result", result, 32'h0);
    chk("mrst_zero", {31'd0, zero}, 32'd1);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    do_op(4'b1000, 32'h3, 32'h4);
    wait_valid(40);
    chk("mul_after_rst", result, 32'hC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/mips_alu_exec.md
Name: mips_alu_exec

Overview:
- Registered, handshaked ALU execute unit. It is the consumer of the 4-bit alu_control code produced by the ALU control decoder.
- Accepts an op code plus two operands and returns a result with a zero flag.
- Single-cycle ops complete in one cycle. MUL is an iterative shift-add over WIDTH cycles.
- Sits in the EX stage of the multi-cycle/pipelined cores, between the register-read operands and writeback.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  op/operands valid
- in_ready  output  1  unit can accept an op this cycle
- alu_control  input  4  op code, sampled on accept
- operand_a  input  WIDTH  first operand, sampled on accept
- operand_b  input  WIDTH  second operand, sampled on accept
- out_valid  output  1  result valid
- out_ready  input  1  downstream consumes the result
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- illegal_op  output  1  accepted code was unsupported
- overflow  output  1  signed overflow (see Optional Feature)

Behaviour:
- Interface:
  - One clock; reset is asynchronous and active-low.
  - Clock is clk, reset is rst_n.
- Op codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0110 SUB (a-b); 0111 SLT.
  - SLT is signed: result 1 if $signed(a) < $signed(b), else 0.
  - 1100 NOR; 1000 MUL, low WIDTH bits of a*b, unsigned.
  - All other codes: result 0, illegal_op 1, single-cycle timing.
  - ADD/SUB wrap modulo 2^WIDTH.
- States: IDLE, MUL, DONE.
- Accept: happens on a rising edge when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Back-to-back ops therefore sustain 1 op/cycle for single-cycle codes.
- Single-cycle op:
  - Accepted at edge N; result/zero/illegal_op registered at edge N.
  - state=DONE and out_valid=1 from edge N (visible in cycle N+1).
- MUL:
  - On accept, latch multiplicand=a, multiplier=b, acc=0, count=0; state=MUL.
  - Each MUL cycle: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++.
  - After WIDTH MUL cycles, result=acc and state=DONE.
  - out_valid rises WIDTH+1 edges after accept. in_ready=0 throughout MUL.
- DONE:
  - result, zero, illegal_op, overflow hold stable while out_valid && !out_ready.
  - out_ready=1 with no new accept: state=IDLE, out_valid=0 next edge.
  - out_ready=1 with a simultaneous accept: the new op is processed; the old result is replaced at the same edge.
- in_valid while busy is ignored; the upstream must hold its request.
- alu_control and operands change while not accepted: no effect.
- Reset, including mid-MUL:
  - state=IDLE; out_valid=0; result=0; zero=1; illegal_op=0; overflow=0.
  - acc, count and shift registers are cleared.
  - in_ready=1 in the first cycle after deassertion.
- zero is always derived from the registered result.

Optional Feature:
- Macro: ALU_OVERFLOW_EN
- Defined: overflow is registered alongside result.
  - ADD: set when operand signs are equal and the result sign differs.
  - SUB: set when operand signs differ and the result sign differs from a.
  - All other ops: 0.
- Not defined: overflow tied 0; no extra logic.
- Port list is identical in both builds.

Test Plan:
- Reset mid-MUL: assert rst_n=0 at cycle 5 of a MUL -> out_valid=0, result=0, zero=1, in_ready=1 in the cycle after release.
- ADD then SUB back-to-back, out_ready=1:
  - ADD 0x00000005+0x00000003 -> result 0x00000008 next cycle.
  - SUB 5-5 -> result 0, zero=1 the following cycle; in_ready stays 1.
- SLT signed: a=0xFFFFFFFF, b=0x00000001 -> result 1. Swapped -> result 0.
- MUL 0x0000000C*0x0000000A:
  - in_ready=0 for 32 cycles.
  - out_valid at edge 33 after accept, result 0x00000078.
  - Result held 3 cycles with out_ready=0.
- Illegal code 0101 -> result 0, illegal_op=1, zero=1, single-cycle.
- ALU_OVERFLOW_EN defined: ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow=1. Undefined: overflow=0.
